// File: rtl/cdc_req_rx_pkg.sv
// Shared CDC request/acknowledge definitions: default widths and the receiver FSM encoding.
// The matching transmitter imports the same package.
package cdc_req_rx_pkg;

  localparam int CDC_DW = 32;
  localparam int CDC_CW = 16;

  typedef enum logic [1:0] {
    ST_WAIT_LOW = 2'd0,
    ST_IDLE     = 2'd1,
    ST_VALID    = 2'd2,
    ST_ACK      = 2'd3
  } cdc_rx_st_e;

endpackage

// File: rtl/cdc_req_rx.sv
// Four-phase request receiver: captures the source payload, presents it as a valid/ready
// stream to the local consumer, and returns a flop-driven acknowledge level.
module cdc_req_rx
  import cdc_req_rx_pkg::*;
#(
  parameter int DW = CDC_DW,
  parameter int CW = CDC_CW
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          req_sync,
  input  logic [DW-1:0] req_data,
  output logic          ack,
  output logic          dout_pvld,
  input  logic          dout_prdy,
  output logic [DW-1:0] dout_pd,
  output logic [CW-1:0] xfer_cnt,
  output logic          err_proto
);

  cdc_rx_st_e    st_q, st_d;
  logic          ack_q, ack_d;
  logic          pvld_q, pvld_d;
  logic [DW-1:0] pd_q, pd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  // ack and pvld are registered copies of the next state, so neither output has a
  // combinational path from any input.
  always_comb begin
    st_d   = st_q;
    ack_d  = 1'b0;
    pvld_d = 1'b0;
    pd_d   = pd_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    case (st_q)
      ST_WAIT_LOW: begin
        // A request still high from before reset is stale; wait for it to drop.
        if (!req_sync) st_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (req_sync) begin
          st_d   = ST_VALID;
          pd_d   = req_data;
          pvld_d = 1'b1;
        end
      end
      ST_VALID: begin
        pvld_d = 1'b1;
        if (!req_sync) err_d = 1'b1;
        if (dout_prdy) begin
          st_d   = ST_ACK;
          pvld_d = 1'b0;
          ack_d  = 1'b1;
          cnt_d  = cnt_q + CW'(1);
        end
      end
      ST_ACK: begin
        ack_d = 1'b1;
        if (!req_sync) begin
          st_d  = ST_IDLE;
          ack_d = 1'b0;
        end
      end
      default: st_d = ST_WAIT_LOW;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      st_q   <= ST_WAIT_LOW;
      ack_q  <= 1'b0;
      pvld_q <= 1'b0;
      pd_q   <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      ack_q  <= ack_d;
      pvld_q <= pvld_d;
      pd_q   <= pd_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign ack       = ack_q;
  assign dout_pvld = pvld_q;
  assign dout_pd   = pd_q;
  assign xfer_cnt  = cnt_q;
  assign err_proto = err_q;

endmodule
